// File: rtl/mux_pkg.sv
// Shared constants for the 8:1 operand multiplexer: select codes and default width.
package mux_pkg;

    localparam int MUX_DEFAULT_N = 32;

    localparam logic [2:0] SEL_I0 = 3'd0;
    localparam logic [2:0] SEL_I1 = 3'd1;
    localparam logic [2:0] SEL_I2 = 3'd2;
    localparam logic [2:0] SEL_I3 = 3'd3;
    localparam logic [2:0] SEL_I4 = 3'd4;
    localparam logic [2:0] SEL_I5 = 3'd5;
    localparam logic [2:0] SEL_I6 = 3'd6;
    localparam logic [2:0] SEL_I7 = 3'd7;

endpackage

// File: rtl/mux_2NtoN.sv
// N-bit 2:1 multiplexer; the leaf cell of the 8:1 select tree.
module mux_2NtoN
    import mux_pkg::*;
#(
    parameter int N = MUX_DEFAULT_N
) (
    input  logic [N-1:0] I0,
    input  logic [N-1:0] I1,
    input  logic         S,
    output logic [N-1:0] O
);

    assign O = S ? I1 : I0;

endmodule

// File: rtl/mux_8n_to_n.sv
// N-bit 8:1 mux with enable, registered copy O_q, and optional parity register
// O_par enabled by defining MUX8_PARITY_EN.
module mux_8n_to_n
    import mux_pkg::*;
#(
    parameter int N = MUX_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] I0,
    input  logic [N-1:0] I1,
    input  logic [N-1:0] I2,
    input  logic [N-1:0] I3,
    input  logic [N-1:0] I4,
    input  logic [N-1:0] I5,
    input  logic [N-1:0] I6,
    input  logic [N-1:0] I7,
    input  logic [2:0]   S,
    input  logic         enable,
    output logic [N-1:0] O,
    output logic [N-1:0] O_q,
    output logic         O_par
);

    logic [N-1:0] lvl0 [8];
    logic [N-1:0] lvl1 [4];
    logic [N-1:0] lvl2 [2];
    logic [N-1:0] tree_out;
    logic [N-1:0] o_q_reg;

    assign lvl0[0] = I0;
    assign lvl0[1] = I1;
    assign lvl0[2] = I2;
    assign lvl0[3] = I3;
    assign lvl0[4] = I4;
    assign lvl0[5] = I5;
    assign lvl0[6] = I6;
    assign lvl0[7] = I7;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_stage0
            mux_2NtoN #(.N(N)) u_mux (
                .I0(lvl0[2*gi]), .I1(lvl0[2*gi+1]), .S(S[0]), .O(lvl1[gi])
            );
        end
        for (gi = 0; gi < 2; gi++) begin : g_stage1
            mux_2NtoN #(.N(N)) u_mux (
                .I0(lvl1[2*gi]), .I1(lvl1[2*gi+1]), .S(S[1]), .O(lvl2[gi])
            );
        end
    endgenerate

    mux_2NtoN #(.N(N)) u_stage2 (
        .I0(lvl2[0]), .I1(lvl2[1]), .S(S[2]), .O(tree_out)
    );

    // AND gating keeps an unknown enable visible as X rather than masking it.
    assign O = tree_out & {N{enable}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) o_q_reg <= '0;
        else      o_q_reg <= O;
    end
    assign O_q = o_q_reg;

`ifdef MUX8_PARITY_EN
    logic par_reg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_reg <= 1'b0;
        else      par_reg <= ^O;
    end
    assign O_par = par_reg;
`else
    assign O_par = 1'b0;
`endif

endmodule

// File: tb/tb_mux_8n_to_n.sv
// Scoreboard bench for mux_8n_to_n: stimulus queues expectations, a monitor checks them.
module tb_mux_8n_to_n;
    import mux_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] I0, I1, I2, I3, I4, I5, I6, I7;
    logic [2:0]   S;
    logic         enable;
    logic [W-1:0] O, O_q;
    logic         O_par;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string        name;
        logic [W-1:0] o;
        logic [W-1:0] q;
        logic         par;
        bit           chk_q;
    } exp_t;

    exp_t sb[$];
    event push_ev;

    always #5 clk = ~clk;

    mux_8n_to_n #(.N(W)) dut (
        .clk(clk), .rst(rst),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3), .I4(I4), .I5(I5), .I6(I6), .I7(I7),
        .S(S), .enable(enable), .O(O), .O_q(O_q), .O_par(O_par)
    );

    function automatic logic par_of(input logic [W-1:0] w);
`ifdef MUX8_PARITY_EN
        return ^w;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_exp(input string name, input logic [W-1:0] o,
                            input logic [W-1:0] q, input bit chk_q);
        exp_t e;
        #1;
        e.name = name; e.o = o; e.q = q; e.par = par_of(q); e.chk_q = chk_q;
        sb.push_back(e);
        -> push_ev;
        #1;
    endtask

    // Monitor: drains the scoreboard each time the stimulus presents a settled output.
    initial begin
        exp_t e;
        forever begin
            @(push_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                if (O !== e.o) begin
                    n_fail++;
                    $display("FAIL %s O: got %h expected %h", e.name, O, e.o);
                end else $display("ok   %s O=%h", e.name, O);
                if (e.chk_q) begin
                    n_assert++;
                    if (O_q !== e.q) begin
                        n_fail++;
                        $display("FAIL %s O_q: got %h expected %h", e.name, O_q, e.q);
                    end
                    n_assert++;
                    if (O_par !== e.par) begin
                        n_fail++;
                        $display("FAIL %s O_par: got %b expected %b", e.name, O_par, e.par);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] vals [8];
        vals[0] = 32'hE59F1020; vals[1] = 32'hAA000004;
        vals[2] = 32'h5224912A; vals[3] = 32'h28A44EAF;
        vals[4] = 32'hFADB6EDB; vals[5] = 32'h122225A8;
        vals[6] = 32'h500A9D49; vals[7] = 32'hE895D275;

        I0 = '0; I1 = '0; I2 = '0; I3 = '0; I4 = '0; I5 = '0; I6 = '0; I7 = '0;
        S = SEL_I0; enable = 1'b0;

        // Reset asserted before the first clock edge, then held across one.
        #3 rst = 1'b0;
        push_exp("reset_no_clk", '0, '0, 1'b1);
        @(posedge clk); #2;
        push_exp("reset_held", '0, '0, 1'b1);
        rst = 1'b1;

        I0 = vals[0]; I1 = vals[1]; I2 = vals[2]; I3 = vals[3];
        I4 = vals[4]; I5 = vals[5]; I6 = vals[6]; I7 = vals[7];
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            S = 3'(k);
            push_exp($sformatf("sweep_s%0d", k), vals[k], '0, 1'b0);
        end

        enable = 1'b0;
        S = SEL_I1; push_exp("disable_s1", '0, '0, 1'b0);
        S = SEL_I2; push_exp("disable_s2", '0, '0, 1'b0);
        S = SEL_I4; push_exp("disable_s4", '0, '0, 1'b0);

        enable = 1'b1; S = SEL_I4;
        @(posedge clk); #2;
        push_exp("reg_capture", 32'hFADB6EDB, 32'hFADB6EDB, 1'b1);
        S = SEL_I0;
        push_exp("reg_hold", 32'hE59F1020, 32'hFADB6EDB, 1'b1);
        rst = 1'b0;
        push_exp("async_reset", 32'hE59F1020, '0, 1'b1);
        rst = 1'b1;

        S = SEL_I1;
        @(posedge clk); #2;
        push_exp("parity_i1", 32'hAA000004, 32'hAA000004, 1'b1);
        S = SEL_I0;
        @(posedge clk); #2;
        push_exp("parity_i0", 32'hE59F1020, 32'hE59F1020, 1'b1);

        // Simultaneous select/enable change, then a disabled capture.
        S = SEL_I7; enable = 1'b0;
        @(posedge clk); #2;
        push_exp("capture_disabled", '0, '0, 1'b1);
        S = SEL_I6; enable = 1'b1;
        @(posedge clk); #2;
        push_exp("capture_s6", 32'h500A9D49, 32'h500A9D49, 1'b1);

        for (int c = 0; c < 100 && sb.size() > 0; c++) @(posedge clk);
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
